// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus sweeper for a dual-rail combinational block: drives every input
// vector, samples after a settle time, checks rail complementarity and compacts resp into a MISR.
module truth_table_sweeper #(
  parameter int unsigned N_INPUTS      = 4,
  parameter int unsigned OUT_W         = 1,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned SIG_W         = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_INPUTS-1:0] stim,
  input  logic [OUT_W-1:0]    resp,
  input  logic [OUT_W-1:0]    resp_n,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic [N_INPUTS-1:0] first_err_vec,
  output logic [SIG_W-1:0]    signature
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // SETTLE | holding stim while the block under test settles
  // SAMPLE | checking and compacting resp for the current stim
  // DONE   | sweep finished, results held until start or reset
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [N_INPUTS-1:0] STIM_LAST = '1;
  localparam logic [N_INPUTS-1:0] STIM_ONE  = N_INPUTS'(1);
  localparam logic [N_INPUTS:0]   ERR_ONE   = (N_INPUTS + 1)'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [SIG_W-1:0] resp_ext;
  logic [SIG_W-1:0] sig_nxt;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SETTLE;
      SETTLE:     if (settle_cnt == '0) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (stim == STIM_LAST) ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp_ext = '0;
    resp_ext[OUT_W-1:0] = resp;
  end

  // Equal rails on any bit is a failure; an X compare leaves the if-branch untaken.
  assign mismatch = |(~(resp ^ resp_n));
  assign sig_nxt  = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                  ^ resp_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim          <= '0;
      settle_cnt    <= '0;
      err_count     <= '0;
      first_err_vec <= '0;
      signature     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            stim          <= '0;
            settle_cnt    <= CNT_LOAD;
            err_count     <= '0;
            first_err_vec <= '0;
            signature     <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_ONE;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            if (err_count == '0) first_err_vec <= stim;
          end
          signature <= sig_nxt;
          if (stim != STIM_LAST) begin
            stim       <= stim + STIM_ONE;
            settle_cnt <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule
